// File: rtl/seq_mul32.sv
// rtl/seq_mul32.sv - sequential 32x32 unsigned shift-add multiplier and its carry-select adder
//
// casqu: 32-bit carry-select adder built from four 8-bit blocks.
//   x, y    : addends
//   cin     : carry in
//   sumo    : 32-bit sum
//   cout    : carry out
//
// seq_mul32: one multiply in flight, fixed 32-step latency, valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : multiplicand, multiplier (unsigned, sampled on accept)
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   product             : {A,Q}, equals a*b while out_valid is high

module casqu (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sumo,
    output logic        cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // Each block precomputes both carry-in outcomes; the rippling carry only drives muxes.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [8:0] s0;
        logic [8:0] s1;

        assign s0 = {1'b0, x[8*g +: 8]} + {1'b0, y[8*g +: 8]};
        assign s1 = {1'b0, x[8*g +: 8]} + {1'b0, y[8*g +: 8]} + 9'd1;

        assign sumo[8*g +: 8] = carry[g] ? s1[7:0] : s0[7:0];
        assign carry[g+1]     = carry[g] ? s1[8]   : s0[8];
    end

    assign cout = carry[4];

endmodule

module seq_mul32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] a_q, a_d;
    logic [31:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [31:0] add_y;
    logic [31:0] add_sum;
    logic        add_cout;

    // Add the multiplicand only when the current multiplier LSB is set.
    assign add_y = q_q[0] ? m_q : 32'h0;

    casqu u_casqu (
        .x    (a_q),
        .y    (add_y),
        .cin  (1'b0),
        .sumo (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    a_d     = 32'h0;
                    q_d     = b;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // {A,Q} <= {cout, sum, Q} >> 1: carry enters A[31], sum LSB enters Q[31].
                a_d   = {add_cout, add_sum[31:1]};
                q_d   = {add_sum[0], q_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= 32'h0;
            a_q     <= 32'h0;
            q_q     <= 32'h0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {a_q, q_q};

endmodule

// File: tb/tb_seq_mul32.sv
// tb/tb_seq_mul32.sv - directed and random self-checking bench for seq_mul32

module tb_seq_mul32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int checks;
    int failures;
    int cyc;

    seq_mul32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge with the block idle; accepts one operation, checks
    // 32-cycle latency and the product, then drains it with out_ready.
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp, input string name);
        int n;
        chk({name, "_in_ready"}, {63'h0, in_ready}, 64'h1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_busy"}, {63'h0, in_ready}, 64'h0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd32);
        chk({name, "_product"}, product, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drained"}, {62'h0, out_valid, in_ready}, 64'h1);
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        int acc_prev;
        logic [31:0] ra, rb;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0,          32'h1234_5678,  64'h0};
        vecs[3] = '{32'h1234_5678,  32'h0,          64'h0};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[7] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[8] = '{32'h0001_0000,  32'h0000_FFFF,  64'h0000_0000_FFFF_0000};
        vecs[9] = '{32'd7,          32'd9,          64'd63};

        // Reset state, both during and after reset.
        #12;
        chk("rst_in_ready",  {63'h0, in_ready},  64'h1);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_product",   product,            64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {62'h0, in_ready, out_valid}, 64'h2);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: DONE holds with new operands offered.
        a        = 32'h0001_0000;
        b        = 32'h0001_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 64'(n), 64'd32);
        in_valid = 1'b1;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1357_9BDF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_product", product, 64'h0000_0001_0000_0000);
            chk("bp_flags", {62'h0, in_ready, out_valid}, 64'h1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_xfer", {62'h0, in_ready, out_valid}, 64'h2);
        chk("bp_product_kept", product, 64'h0000_0001_0000_0000);

        // Asynchronous reset 10 cycles into RUN.
        a        = 32'h0BAD_F00D;
        b        = 32'h1234_5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flags",   {62'h0, in_ready, out_valid}, 64'h2);
        chk("mid_rst_product", product, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd7, 32'd9, 64'd63, "after_rst");

        // Back-to-back random operands with in_valid and out_ready held high.
        out_ready = 1'b1;
        acc_prev  = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!in_ready) begin
                chk("b2b_ready", {63'h0, in_ready}, 64'h1);
            end
            ra       = $urandom;
            rb       = $urandom;
            a        = ra;
            b        = rb;
            in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_spacing", 64'(cyc - acc_prev), 64'd34);
            end
            acc_prev = cyc;
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_latency", 64'(n), 64'd32);
            chk("b2b_product", product, {32'h0, ra} * {32'h0, rb});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
